// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the ARM core, the secondary loader/DMA requester and the data memory.
// The arbiter takes the slave view; the core/loader/memory environment takes the master view.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic [31:0] ld_rdata;
  logic        ld_rvalid;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rdata, ld_rvalid,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rdata, ld_rvalid,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: the core has fixed priority, the loader is served in idle slots.
// Define DMEM_ARB_STARVATION_EN to build the starvation guard (one-cycle core stall after MAX_WAIT denials).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal arbitration, core wins over loader
// ST_STALL | core frozen for one cycle, loader gets a forced grant
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  logic        stall_q;
  logic        ld_own;
  logic        ld_rvalid_q;
  logic [31:0] ld_rdata_q;
  logic [15:0] ld_xfers;

  // Ownership: forced grant, then core, then loader; nothing is granted while in reset.
  always_comb begin
    ld_own = 1'b0;
    if (!reset) begin
      if (stall_q)
        ld_own = bus.ld_req;
      else if (bus.cpu_req)
        ld_own = 1'b0;
      else
        ld_own = bus.ld_req;
    end
  end

  always_comb begin
    bus.ld_gnt    = ld_own;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_we    = bus.cpu_we & bus.cpu_req & ~stall_q & ~reset;
    if (ld_own) begin
      bus.mem_addr  = bus.ld_addr;
      bus.mem_wdata = bus.ld_wdata;
      bus.mem_we    = bus.ld_we;
    end
  end

  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.cpu_stall = stall_q;
  assign bus.ld_rdata  = ld_rdata_q;
  assign bus.ld_rvalid = ld_rvalid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_rvalid_q <= 1'b0;
      ld_rdata_q  <= 32'd0;
      ld_xfers    <= 16'd0;
    end else begin
      ld_rvalid_q <= ld_own & ~bus.ld_we;
      if (ld_own & ~bus.ld_we)
        ld_rdata_q <= bus.mem_rdata;
      if (ld_own)
        ld_xfers <= ld_xfers + 16'd1;
    end
  end

`ifdef DMEM_ARB_STARVATION_EN
  typedef enum logic {ST_RUN, ST_STALL} state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt, wait_cnt_d;
  logic       denied;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      wait_cnt <= 8'd0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // The stall lasts one cycle; the denial that reaches MAX_WAIT schedules it and restarts the count.
  always_comb begin
    state_d    = ST_RUN;
    wait_cnt_d = 8'd0;
    denied     = bus.ld_req & ~ld_own;
    if (denied) begin
      if (wait_cnt + 8'd1 == MAX_WAIT_C)
        state_d = ST_STALL;
      else
        wait_cnt_d = wait_cnt + 8'd1;
    end
  end

  assign stall_q = (state_q == ST_STALL);
`else
  assign stall_q = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed stimulus, a reference model checked every cycle,
// and literal expectations for the scenarios of interest (both starvation-guard builds).
module tb_dmem_arbiter;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Data memory device: combinational read, write at the rising edge.
  logic [31:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model, sampled mid-cycle when inputs are stable; the state update stands for the next edge.
  logic [31:0] ref_mem [0:63];
  bit          m_valid = 0;
  bit          m_stall, m_rv;
  logic [31:0] m_rdata;
  int          m_den, m_xfers;

  initial begin
    logic        e_gnt, e_we;
    logic [31:0] e_addr, e_wdata;
    bit          nstall;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 | i;
    forever begin
      @(negedge clk);
      if (reset)                     e_gnt = 1'b0;
      else if (m_stall)              e_gnt = bus.ld_req;
      else if (bus.cpu_req)          e_gnt = 1'b0;
      else                           e_gnt = bus.ld_req;
      e_addr  = e_gnt ? bus.ld_addr  : bus.cpu_addr;
      e_wdata = e_gnt ? bus.ld_wdata : bus.cpu_wdata;
      e_we    = reset ? 1'b0 : (e_gnt ? bus.ld_we : (bus.cpu_we & bus.cpu_req & !m_stall));

      chk("m_ld_gnt",    bus.ld_gnt,    e_gnt);
      chk("m_mem_we",    bus.mem_we,    e_we);
      chk("m_mem_addr",  bus.mem_addr,  e_addr);
      chk("m_mem_wdata", bus.mem_wdata, e_wdata);
      chk("m_cpu_rdata", bus.cpu_rdata, ref_mem[e_addr[7:2]]);
      if (m_valid) begin
        chk("m_cpu_stall", bus.cpu_stall, m_stall);
        chk("m_ld_rvalid", bus.ld_rvalid, m_rv);
        chk("m_ld_rdata",  bus.ld_rdata,  m_rdata);
        chk("m_ld_xfers",  dut.ld_xfers,  m_xfers[15:0]);
      end

      if (reset) begin
        m_valid = 1; m_stall = 0; m_rv = 0; m_rdata = 0; m_den = 0; m_xfers = 0;
      end else begin
        m_rv = e_gnt && !bus.ld_we;
        if (m_rv) m_rdata = ref_mem[bus.ld_addr[7:2]];
        if (e_we) ref_mem[e_addr[7:2]] = e_wdata;
        if (e_gnt) m_xfers = (m_xfers + 1) % 65536;
        nstall = 0;
`ifdef DMEM_ARB_STARVATION_EN
        if (bus.ld_req && !e_gnt) begin
          m_den++;
          if (m_den == MAXW) begin nstall = 1; m_den = 0; end
        end else m_den = 0;
`endif
        m_stall = nstall;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_gnt, seen_stall;
    reset = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = 32'h40; bus.ld_wdata = 32'h1111_1111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ld_gnt", bus.ld_gnt, 1'b0);
      chk("rst_mem_we", bus.mem_we, 1'b0);
      next_cycle();
    end
    reset = 1'b0; bus.ld_req = 0; bus.ld_we = 0;
    @(negedge clk);
    chk("post_rst_stall",  bus.cpu_stall, 1'b0);
    chk("post_rst_rvalid", bus.ld_rvalid, 1'b0);
    chk("post_rst_rdata",  bus.ld_rdata,  32'h0);
    next_cycle();

    // idle core: loader write, then read back
    bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = 32'h40; bus.ld_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ldw_gnt",    bus.ld_gnt, 1'b1);
    chk("ldw_mem_we", bus.mem_we, 1'b1);
    next_cycle();
    bus.ld_we = 0;
    @(negedge clk);
    chk("ldr_gnt",    bus.ld_gnt, 1'b1);
    chk("ldr_mem_we", bus.mem_we, 1'b0);
    next_cycle();
    bus.ld_req = 0;
    @(negedge clk);
    chk("ldr_rvalid", bus.ld_rvalid, 1'b1);
    chk("ldr_rdata",  bus.ld_rdata,  32'hDEAD_BEEF);
    chk("ldr_xfers",  dut.ld_xfers,  16'd2);
    next_cycle();
    @(negedge clk);
    chk("ldr_rvalid_pulse", bus.ld_rvalid, 1'b0);
    next_cycle();

    // core priority over a simultaneous loader read
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h80; bus.cpu_wdata = 32'h1234_5678;
    bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = 32'h40;
    @(negedge clk);
    chk("prio_mem_addr", bus.mem_addr, 32'h80);
    chk("prio_ld_gnt",   bus.ld_gnt,   1'b0);
    chk("prio_mem_we",   bus.mem_we,   1'b1);
    next_cycle();
    bus.cpu_req = 0; bus.cpu_we = 0;
    @(negedge clk);
    chk("prio_after_gnt", bus.ld_gnt, 1'b1);
    next_cycle();

    // back-to-back reads, each with its own rvalid pulse
    bus.ld_addr = 32'h80;
    @(negedge clk);
    chk("b2b_rdata0", bus.ld_rdata, 32'hDEAD_BEEF);
    next_cycle();
    bus.ld_req = 0;
    @(negedge clk);
    chk("b2b_rvalid1", bus.ld_rvalid, 1'b1);
    chk("b2b_rdata1",  bus.ld_rdata,  32'h1234_5678);
    next_cycle();

`ifdef DMEM_ARB_STARVATION_EN
    // starvation guard with continuous core traffic
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h84;
    bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = 32'h80;
    for (int c = 0; c < 6; c++) begin
      bus.cpu_wdata = 32'hC0DE_0000 + c;
      if (c == 5) bus.ld_req = 0;
      @(negedge clk);
      if (c < 4) chk("starve_denied", bus.ld_gnt, 1'b0);
      if (c == 4) begin
        chk("starve_stall",  bus.cpu_stall, 1'b1);
        chk("starve_gnt",    bus.ld_gnt,    1'b1);
        chk("starve_mem_we", bus.mem_we,    1'b0);
      end
      if (c == 5) chk("starve_release", bus.cpu_stall, 1'b0);
      next_cycle();
    end

    // withdrawal restarts the count
    for (int c = 0; c < 9; c++) begin
      bus.ld_req = (c != 3);
      @(negedge clk);
      if (c < 8) chk("wd_denied", bus.ld_gnt, 1'b0);
      else begin
        chk("wd_gnt",   bus.ld_gnt,    1'b1);
        chk("wd_stall", bus.cpu_stall, 1'b1);
      end
      next_cycle();
    end
    bus.ld_req = 0;
    next_cycle();

    // reset during the last denied cycle drops the pending stall
    bus.ld_req = 1;
    for (int c = 0; c < 5; c++) begin
      reset = (c == 3);
      @(negedge clk);
      if (c == 4) begin
        chk("rst_stall_dropped", bus.cpu_stall, 1'b0);
        chk("rst_stall_gnt",     bus.ld_gnt,    1'b0);
      end
      next_cycle();
    end
    bus.ld_req = 0; bus.cpu_req = 0; bus.cpu_we = 0;
    next_cycle();
`else
    // without the guard the loader starves while the core is busy
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h84;
    bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = 32'h40;
    seen_gnt = 0; seen_stall = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.ld_gnt !== 1'b0)    seen_gnt = 1;
      if (bus.cpu_stall !== 1'b0) seen_stall = 1;
      next_cycle();
    end
    chk("nostarve_gnt_seen",   {31'd0, seen_gnt},   32'd0);
    chk("nostarve_stall_seen", {31'd0, seen_stall}, 32'd0);
    bus.cpu_req = 0;
    @(negedge clk);
    chk("nostarve_gnt_on_idle", bus.ld_gnt, 1'b1);
    next_cycle();
    bus.ld_req = 0;
    next_cycle();
`endif

    next_cycle();
    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter for the single-cycle ARM core's data-memory port. It sits between the core's load/store signals and the data memory and peripheral block, and lets a secondary requester (boot loader / debug DMA) share the memory. The core has fixed priority because it cannot wait on memory. A compile-time starvation guard can freeze the core for one cycle so that a waiting loader is guaranteed service.

## Interface
- MAX_WAIT, 8: denied loader cycles before a forced grant; legal range 1..255.

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  core executes a load/store this cycle
- cpu_we  in  1  core store enable (MemWrite)
- cpu_addr  in  32  core data address
- cpu_wdata  in  32  core store data
- cpu_rdata  out  32  read data to core
- cpu_stall  out  1  registered; core must hold PC and suppress register/memory writes
- ld_req  in  1  loader request; held with stable ld_we/ld_addr/ld_wdata until granted
- ld_we  in  1  loader write enable
- ld_addr  in  32  loader address
- ld_wdata  in  32  loader write data
- ld_gnt  out  1  combinational grant; transfer completes at the edge where ld_req & ld_gnt
- ld_rdata  out  32  registered loader read data
- ld_rvalid  out  1  one-cycle pulse; ld_rdata is valid
- mem_we  out  1  to data memory
- mem_addr  out  32  to data memory
- mem_wdata  out  32  to data memory
- mem_rdata  in  32  combinational read data from memory

## Operation
- Ownership per cycle, in priority order:
  - If cpu_stall=1 and ld_req=1: loader owns the port (forced grant).
  - Else if cpu_req=1: core owns the port.
  - Else if ld_req=1: loader owns the port.
  - Else: idle.
- Mux:
  - Loader owner: mem_addr/mem_wdata come from ld_*, mem_we=ld_we, ld_gnt=1.
  - Otherwise: mem_addr/mem_wdata come from cpu_*, mem_we=cpu_we & cpu_req & ~cpu_stall, ld_gnt=0.
- cpu_rdata = mem_rdata at all times. The core ignores it when stalled.
- Loader read: when ld_gnt & ~ld_we at an edge, ld_rdata <= mem_rdata and ld_rvalid=1 for the next cycle only. Loader writes produce no rvalid.
- wait_cnt (8 bits):
  - Increments at each edge with ld_req & ~ld_gnt.
  - Clears at each edge with ld_gnt or ~ld_req.
  - When a denial makes it reach MAX_WAIT, stall_q is set for exactly the next cycle and wait_cnt clears.
- stall_q drives cpu_stall and self-clears after one cycle. If ld_req is low in the stall cycle (protocol violation), the cycle is idle: mem_we=0 and no grant.
- ld_xfers (16 bits): counts completed loader transfers and wraps 0xFFFF -> 0. It is internal and visible to the bench through hierarchy.

## Timing
- Reset (sampled high at an edge) clears wait_cnt, stall_q, ld_rvalid, ld_rdata and ld_xfers to 0.
  - After that edge: cpu_stall=0, ld_rvalid=0, ld_rdata=0.
  - While reset is high: ld_gnt=0 and mem_we=0, regardless of requests.
  - Reset mid-stall or mid-read drops the pending stall and rvalid.
- Grant latency:
  - Idle core: 0 cycles, since ld_gnt is asserted in the same cycle as ld_req.
  - Continuous cpu_req: exactly MAX_WAIT denied cycles, then the grant in cycle MAX_WAIT counted from the first request cycle.
- Read data latency: ld_rvalid is asserted 1 cycle after the grant cycle.
- Back-to-back loader transfers are allowed: keep ld_req high with new address/data after each granted edge. Each granted read produces its own rvalid pulse.
- Simultaneous cpu_req and ld_req with cpu_stall=0: the core wins.

## Configuration
- DMEM_ARB_STARVATION_EN defined: wait_cnt, stall_q and the forced grant are present as described.
- Not defined:
  - cpu_stall is tied 0 and wait_cnt/stall_q are not built.
  - The loader is served only in cycles with cpu_req=0 and may starve indefinitely.
  - MAX_WAIT is ignored.

## Test plan
- Reset check: hold reset 2 cycles with ld_req=1, ld_we=1, cpu_req=0 -> ld_gnt=0 and mem_we=0 throughout. After release, cpu_stall=0 and ld_rvalid=0.
- Idle-core loader write then read:
  - Write: ld_req=1, ld_we=1, ld_addr=0x40, ld_wdata=0xDEADBEEF -> ld_gnt=1 and mem_we=1 in the same cycle.
  - Read: next cycle, read of 0x40 -> ld_rvalid=1 one cycle later with ld_rdata=0xDEADBEEF, and ld_xfers=2.
- Core priority: cpu_req=1 and cpu_we=1 (addr 0x80) in the same cycle as ld_req=1 (addr 0x40) -> mem_addr=0x80 and ld_gnt=0.
- Starvation guard, macro defined, MAX_WAIT=4: cpu_req held high, ld_req rises at cycle 0 -> ld_gnt=0 in cycles 0-3; cpu_stall=1 and ld_gnt=1 in cycle 4; cpu_stall=0 in cycle 5.
- Request withdrawal: MAX_WAIT=4, ld_req high for cycles 0-2, low in cycle 3, high again from cycle 4 with cpu_req continuously high -> first forced grant in cycle 8.
- Macro undefined: cpu_req high for 300 cycles with ld_req high -> cpu_stall never 1, ld_gnt=0 for all 300 cycles, grant in the first cycle cpu_req drops.
